// File: rtl/spi_poll_sequencer_pkg.sv
// Shared definitions for the SPI poll sequencer: FSM states, slave select and SPI mode codes.
package spi_poll_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StGap
  } state_e;

  localparam int unsigned NUM_SLAVES = 3;

  localparam logic [1:0] SSI_S1 = 2'b01;
  localparam logic [1:0] SSI_S2 = 2'b10;
  localparam logic [1:0] SSI_S3 = 2'b11;

  // SPI mode codes, {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Slave index 0..2 to ssi code 01..11
  function automatic logic [1:0] ssi_of_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  // ssi code to slave index; 00 aliases S1
  function automatic logic [1:0] idx_of_ssi(input logic [1:0] ssi);
    return (ssi == 2'b00) ? 2'd0 : ssi - 2'd1;
  endfunction

endpackage

// File: rtl/spi_poll_sequencer_if.sv
// Command/response bus between the poll sequencer and the SPI master.
interface spi_poll_sequencer_if;
  import spi_poll_sequencer_pkg::*;

  logic       sendOrder;
  logic [1:0] ssi;
  logic [7:0] address;
  logic [1:0] mode;
  logic [7:0] sensor;

  modport master (
    output sendOrder,
    output ssi,
    output address,
    output mode,
    input  sensor
  );

  modport slave (
    input  sendOrder,
    input  ssi,
    input  address,
    input  mode,
    output sensor
  );

endinterface

// File: rtl/spi_result_table.sv
// 3 x NUM_REGS byte table: one write port, one registered read port, async clear.
module spi_result_table
  import spi_poll_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned RegW     = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [1:0]      wr_slave,
  input  logic [RegW-1:0] wr_reg,
  input  logic [7:0]      wr_data,
  input  logic [1:0]      rd_slave,
  input  logic [RegW-1:0] rd_reg,
  output logic [7:0]      rd_data
);

  logic [7:0] mem [NUM_SLAVES][NUM_REGS];
  logic [1:0] rd_idx;

  assign rd_idx = idx_of_ssi(rd_slave);

  // Storage and read register; a same-cycle read of the written entry returns the old byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < int'(NUM_SLAVES); s++) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          mem[s][r] <= '0;
        end
      end
      rd_data <= '0;
    end else begin
      if (we) begin
        mem[wr_slave][wr_reg] <= wr_data;
      end
      rd_data <= mem[rd_idx][rd_reg];
    end
  end

endmodule

// File: rtl/spi_poll_sequencer.sv
// Sweeps every register of every SPI slave, capturing each returned byte into a table and
// a per-sample stream.
module spi_poll_sequencer
  import spi_poll_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned XFER_CYCLES = 40,
  parameter int unsigned GAP_CYCLES  = 4,
  localparam int unsigned RegW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode_cfg,
  spi_poll_sequencer_if.master  spi,
  output logic                  sample_valid,
  output logic [1:0]            sample_slave,
  output logic [7:0]            sample_addr,
  output logic [7:0]            sample_data,
  output logic                  sweep_done,
  output logic                  busy,
  input  logic [1:0]            rd_slave,
  input  logic [RegW-1:0]       rd_reg,
  output logic [7:0]            rd_data
);

  localparam int unsigned CntMax = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  state_e          state;
  logic [1:0]      slave_idx;
  logic [RegW-1:0] reg_idx;
  logic [CntW-1:0] cnt;

  logic            last_reg;
  logic            last_access;
  logic [1:0]      slave_nxt;
  logic [RegW-1:0] reg_nxt;

  // Index advance: register first, then slave, wrapping S3 back to S1
  always_comb begin
    last_reg    = (reg_idx == RegW'(NUM_REGS - 1));
    last_access = last_reg && (slave_idx == 2'(NUM_SLAVES - 1));
    reg_nxt     = last_reg ? '0 : reg_idx + RegW'(1);
    slave_nxt   = slave_idx;
    if (last_reg) begin
      slave_nxt = last_access ? 2'd0 : slave_idx + 2'd1;
    end
  end

  // Sequencer FSM with registered bus, sample and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= StIdle;
      slave_idx     <= '0;
      reg_idx       <= '0;
      cnt           <= '0;
      spi.sendOrder <= 1'b0;
      spi.ssi       <= SSI_S1;
      spi.address   <= '0;
      spi.mode      <= MODE0;
      sample_valid  <= 1'b0;
      sample_slave  <= '0;
      sample_addr   <= '0;
      sample_data   <= '0;
      sweep_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      spi.sendOrder <= 1'b0;
      sample_valid  <= 1'b0;
      sweep_done    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (enable) begin
            spi.mode      <= mode_cfg;
            slave_idx     <= '0;
            reg_idx       <= '0;
            spi.ssi       <= ssi_of_idx(2'd0);
            spi.address   <= '0;
            spi.sendOrder <= 1'b1;
            busy          <= 1'b1;
            state         <= StIssue;
          end
        end
        StIssue: begin
          cnt   <= CntW'(XFER_CYCLES - 1);
          state <= StWait;
        end
        StWait: begin
          if (cnt == '0) begin
            state <= StCapture;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StCapture: begin
          sample_valid <= 1'b1;
          sample_slave <= spi.ssi;
          sample_addr  <= spi.address;
          sample_data  <= spi.sensor;
          sweep_done   <= last_access;
          cnt          <= CntW'(GAP_CYCLES - 1);
          state        <= StGap;
        end
        StGap: begin
          if (cnt != '0) begin
            cnt <= cnt - CntW'(1);
          end else begin
            slave_idx <= slave_nxt;
            reg_idx   <= reg_nxt;
            if (enable) begin
              // A new sweep picks up the mode requested at its start
              if (last_access) begin
                spi.mode <= mode_cfg;
              end
              spi.ssi       <= ssi_of_idx(slave_nxt);
              spi.address   <= 8'(reg_nxt);
              spi.sendOrder <= 1'b1;
              state         <= StIssue;
            end else begin
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  spi_result_table #(
    .NUM_REGS (NUM_REGS),
    .RegW     (RegW)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (state == StCapture),
    .wr_slave (slave_idx),
    .wr_reg   (reg_idx),
    .wr_data  (spi.sensor),
    .rd_slave (rd_slave),
    .rd_reg   (rd_reg),
    .rd_data  (rd_data)
  );

endmodule
